// File: rtl/stack_mem_responder.sv
// rtl/stack_mem_responder.sv - word-addressed memory responder with fixed wait states and a mapped LED register
module stack_mem_responder #(
   parameter int          ADDR_BITS   = 10,
   parameter int          WAIT_STATES = 1,
   parameter logic [15:0] LED_ADDR    = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ready,
   output logic        err,
   output logic [7:0]  leds
);

   localparam int         DEPTH = 1 << ADDR_BITS;
   localparam logic [3:0] WS    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [15:0] lat_addr;
   logic [15:0] lat_wdata;
   logic        lat_we;
   logic [15:0] mem [DEPTH];

   logic [15:0]          cur_addr;
   logic [15:0]          cur_wdata;
   logic                 cur_we;
   logic                 accept;
   logic                 commit;
   logic                 hit_led;
   logic                 hit_ram;
   logic [ADDR_BITS-1:0] ram_idx;

   // With zero wait states the commit happens on the accepting edge, so decode the live inputs there
   always_comb begin
      accept    = (state == IDLE) && req;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_we    = lat_we;
      if (state == IDLE) begin
         cur_addr  = addr;
         cur_wdata = wdata;
         cur_we    = we;
      end
      commit  = rst_n && ((accept && (WS == 4'd0)) || ((state == WAIT) && (cnt == 4'd1)));
      hit_led = (cur_addr == LED_ADDR);
      hit_ram = !hit_led && ((cur_addr >> ADDR_BITS) == 16'd0);
      ram_idx = cur_addr[ADDR_BITS-1:0];
   end

   // Request sequencing, response pulse, read data and LED register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         lat_addr  <= 16'h0000;
         lat_wdata <= 16'h0000;
         lat_we    <= 1'b0;
         ready     <= 1'b0;
         err       <= 1'b0;
         rdata     <= 16'h0000;
         leds      <= 8'h00;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  lat_addr  <= addr;
                  lat_wdata <= wdata;
                  lat_we    <= we;
                  cnt       <= WS;
                  state     <= (WS == 4'd0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (commit) begin
            ready <= 1'b1;
            err   <= !hit_led && !hit_ram;
            if (cur_we) begin
               if (hit_led) leds <= cur_wdata[7:0];
            end else if (hit_led) begin
               rdata <= {8'h00, leds};
            end else if (hit_ram) begin
               rdata <= mem[ram_idx];
            end else begin
               rdata <= 16'h0000;
            end
         end
      end
   end

   // Backing RAM store; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (commit && cur_we && hit_ram) mem[ram_idx] <= cur_wdata;
   end

endmodule

// File: tb/tb_stack_mem_responder.sv
// tb/tb_stack_mem_responder.sv - self-checking bench for stack_mem_responder at 0, 1 and 3 wait states
module tb_stack_mem_responder;

   localparam int WSV [3] = '{0, 1, 3};

   logic        clk = 1'b0;
   logic        rst_n [3];
   logic        req   [3];
   logic        we    [3];
   logic [15:0] addr  [3];
   logic [15:0] wdata [3];
   logic [15:0] rdata [3];
   logic        ready [3];
   logic        err   [3];
   logic [7:0]  leds  [3];

   always #5 clk = ~clk;

   stack_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(0), .LED_ADDR(16'hFFFF)) u0 (
      .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
      .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .leds(leds[0]));
   stack_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(1), .LED_ADDR(16'hFFFF)) u1 (
      .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
      .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .leds(leds[1]));
   stack_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(3), .LED_ADDR(16'hFFFF)) u2 (
      .clk(clk), .rst_n(rst_n[2]), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
      .rdata(rdata[2]), .ready(ready[2]), .err(err[2]), .leds(leds[2]));

   int checks = 0;
   int errors = 0;

   // reference model: sparse word store per instance, LED byte, last read data
   logic [15:0] mem_m [int];
   logic [7:0]  leds_m  [3];
   logic [15:0] rdata_m [3];

   typedef struct {
      int          inst;
      bit          w;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp_rd;
      bit          exp_err;
      logic [7:0]  exp_leds;
   } vec_t;

   vec_t tbl [$];

   function automatic int key(input int i, input logic [15:0] a);
      return i * 65536 + int'(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_apply(input int i, input bit w, input logic [15:0] a, input logic [15:0] d,
                              output bit e);
      e = 1'b0;
      if (a == 16'hFFFF) begin
         if (w) leds_m[i] = d[7:0];
         else   rdata_m[i] = {8'h00, leds_m[i]};
      end else if (a < 16'd1024) begin
         if (w) mem_m[key(i, a)] = d;
         else   rdata_m[i] = mem_m[key(i, a)];
      end else begin
         e = 1'b1;
         if (!w) rdata_m[i] = 16'h0000;
      end
   endtask

   task automatic do_txn(input int i, input bit w, input logic [15:0] a, input logic [15:0] d,
                         input bit hold, output logic [15:0] got_rd, output logic got_err,
                         output logic [7:0] got_leds);
      bit e;
      int n;
      @(negedge clk);
      req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
      model_apply(i, w, a, d, e);
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (!hold) req[i] = 1'b0;
         addr[i]  = 16'($urandom);
         wdata[i] = 16'($urandom);
         we[i]    = 1'($urandom);
         if (ready[i]) break;
      end
      req[i] = 1'b0;
      chk($sformatf("u%0d latency a=%h", i, a), n, WSV[i] + 1);
      got_rd = rdata[i]; got_err = err[i]; got_leds = leds[i];
      chk($sformatf("u%0d err a=%h", i, a), err[i], e);
      chk($sformatf("u%0d rdata a=%h", i, a), rdata[i], rdata_m[i]);
      chk($sformatf("u%0d leds a=%h", i, a), leds[i], leds_m[i]);
      @(posedge clk); #1;
      chk($sformatf("u%0d ready_pulse", i), {ready[i], err[i]}, 2'b00);
      chk($sformatf("u%0d rdata_held", i), rdata[i], rdata_m[i]);
      if (hold) begin
         repeat (WSV[i] + 3) begin
            @(posedge clk); #1;
            chk($sformatf("u%0d single_resp", i), ready[i], 1'b0);
         end
      end
   endtask

   initial begin
      logic [15:0] grd;
      logic        gerr;
      logic [7:0]  gled;
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = 16'h0; wdata[i] = 16'h0;
         leds_m[i] = 8'h00; rdata_m[i] = 16'h0000;
      end

      tbl.push_back('{1, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, 8'h00});
      tbl.push_back('{1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 8'h00});
      tbl.push_back('{0, 1'b1, 16'h03FF, 16'h1234, 16'h0000, 1'b0, 8'h00});
      tbl.push_back('{0, 1'b0, 16'h03FF, 16'h0000, 16'h1234, 1'b0, 8'h00});
      tbl.push_back('{0, 1'b1, 16'h0000, 16'h5555, 16'h1234, 1'b0, 8'h00});
      tbl.push_back('{0, 1'b0, 16'h03FF, 16'h0000, 16'h1234, 1'b0, 8'h00});
      tbl.push_back('{0, 1'b1, 16'hFFFF, 16'hA55A, 16'h1234, 1'b0, 8'h5A});
      tbl.push_back('{0, 1'b0, 16'hFFFF, 16'h0000, 16'h005A, 1'b0, 8'h5A});
      tbl.push_back('{0, 1'b1, 16'h0400, 16'h7777, 16'h005A, 1'b1, 8'h5A});
      tbl.push_back('{0, 1'b0, 16'h0000, 16'h0000, 16'h5555, 1'b0, 8'h5A});
      tbl.push_back('{0, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 8'h5A});
      tbl.push_back('{2, 1'b1, 16'h0010, 16'h2222, 16'h0000, 1'b0, 8'h00});
      tbl.push_back('{2, 1'b0, 16'h0010, 16'h0000, 16'h2222, 1'b0, 8'h00});

      // reset, then idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         for (int i = 0; i < 3; i++)
            chk($sformatf("u%0d idle_after_reset", i), {ready[i], err[i], rdata[i], leds[i]}, 26'h0);
      end

      // directed table
      foreach (tbl[k]) begin
         do_txn(tbl[k].inst, tbl[k].w, tbl[k].a, tbl[k].d, 1'b0, grd, gerr, gled);
         chk($sformatf("vec%0d rdata", k), grd, tbl[k].exp_rd);
         chk($sformatf("vec%0d err", k), gerr, tbl[k].exp_err);
         chk($sformatf("vec%0d leds", k), gled, tbl[k].exp_leds);
      end

      // reset in the middle of a write on the 3-wait-state instance
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0010; wdata[2] = 16'h1111;
      @(posedge clk); #1;
      req[2] = 1'b0;
      chk("abort ready_before_reset", ready[2], 1'b0);
      rst_n[2] = 1'b0;
      leds_m[2] = 8'h00; rdata_m[2] = 16'h0000;
      @(posedge clk); #1;
      chk("abort state_in_reset", {ready[2], err[2], rdata[2], leds[2]}, 26'h0);
      @(negedge clk);
      rst_n[2] = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         chk("abort no_ready", ready[2], 1'b0);
      end
      do_txn(2, 1'b0, 16'h0010, 16'h0000, 1'b0, grd, gerr, gled);
      chk("abort ram_kept", grd, 16'h2222);

      // req held high through WAIT must yield a single response
      do_txn(2, 1'b1, 16'h0011, 16'h3333, 1'b1, grd, gerr, gled);
      do_txn(1, 1'b0, 16'h0005, 16'h0000, 1'b1, grd, gerr, gled);

      // randomized traffic against the model
      for (int i = 0; i < 3; i++) begin
         for (int t = 0; t < 40; t++) begin
            int          cat;
            bit          w;
            logic [15:0] a;
            cat = int'($urandom_range(0, 9));
            w   = 1'($urandom);
            if (cat < 6) begin
               a = $urandom_range(0, 1) ? 16'($urandom_range(0, 15)) : 16'(16'h03F0 + $urandom_range(0, 15));
               if (!mem_m.exists(key(i, a))) w = 1'b1;
            end else if (cat < 8) begin
               a = 16'hFFFF;
            end else begin
               a = 16'(16'h0400 + $urandom_range(0, 16'hFBFE));
            end
            do_txn(i, w, a, 16'($urandom), ($urandom_range(0, 7) == 0), grd, gerr, gled);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_mem_responder.md
Name: stack_mem_responder

Overview:
- Word-addressed memory responder serving the stack CPU's fetch and data bus.
- Accepts one read or write request at a time and services it after a fixed, parameterised wait-state latency.
- Returns read data with a one-cycle ready pulse.
- Also hosts a memory-mapped 8-bit LED register, so the CPU's LED output is driven through a bus store rather than wired directly.

Parameters:
ADDR_BITS, 10, log2 of backing RAM depth in 16-bit words (default 1024 words)
WAIT_STATES, 1, extra cycles between request acceptance and response (0..15)
LED_ADDR, 16'hFFFF, word address of the LED register

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  request strobe, sampled only in IDLE
we  input  1  1 = write, 0 = read; sampled with req
addr  input  16  word address (CPU drives ip[15:1])
wdata  input  16  write data; sampled with req
rdata  output  16  read data, valid while ready=1, held until next read response
ready  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse coincident with ready when the address decoded to nothing
leds  output  8  LED register contents

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ready=0, err=0, rdata=16'h0000, leds=8'h00, wait counter=0.
  - RAM contents are not reset.
  - Reset asserted mid-transaction aborts it: no RAM or LED write, no ready pulse after release.
- State machine IDLE -> WAIT -> RESP -> IDLE:
  - IDLE: on an edge with req=1, latch addr/we/wdata and load counter=WAIT_STATES. Next state is WAIT if WAIT_STATES>0, else RESP.
  - WAIT: decrement counter each edge; move to RESP on the edge where counter==1.
  - RESP: ready=1 for exactly this one cycle, then IDLE unconditionally. req is ignored in RESP and WAIT.
- Latency and throughput:
  - ready is high in the cycle beginning WAIT_STATES+1 edges after the accepting edge.
  - Back-to-back throughput is one transaction per WAIT_STATES+2 cycles.
- Commit: the write and the rdata update occur on the edge entering RESP. Inputs changing after acceptance have no effect.
- Address decode, using the latched address:
  - addr==LED_ADDR:
    - write: leds <= wdata[7:0], wdata[15:8] ignored.
    - read: rdata <= {8'h00, leds}.
  - addr[15:ADDR_BITS]==0: RAM word addr[ADDR_BITS-1:0].
    - write stores wdata.
    - read returns the stored word. Read-after-write to the same word in consecutive transactions returns the new data.
  - Otherwise:
    - err=1 alongside ready.
    - write discarded.
    - read sets rdata <= 16'h0000.
- Unwritten RAM words read as X in simulation; the bench must not depend on their value.
- rdata is unchanged by write transactions.
- ready and err are never high outside RESP.

Test Plan:
- Reset then idle 10 cycles -> ready=0, err=0, rdata=0000, leds=00 throughout.
- WAIT_STATES=1:
  - req/we=1, addr=0005, wdata=BEEF.
  - Then read of addr 0005.
  - Required: ready exactly 2 edges after each accept; read returns rdata=BEEF; rdata held after ready drops.
- WAIT_STATES=0:
  - Write 1234 to addr 03FF, then read 03FF.
  - Required: ready one edge after accept; readback 1234.
  - Wrap check: write to addr 0000 and read 03FF again returns 1234 (no aliasing).
- LED register:
  - Write wdata=A55A to FFFF -> leds=5A from the RESP cycle.
  - Read FFFF -> rdata=005A.
  - err stays 0.
- Decode error:
  - Write 7777 to addr 0400 -> ready and err pulse together; RAM word 0000 unchanged.
  - Read 0400 -> rdata=0000 with err=1.
- Reset mid-operation:
  - WAIT_STATES=3, write 1111 to addr 0010 after 0010 previously held 2222.
  - Pull rst_n low in WAIT.
  - Required: no ready pulse; subsequent read of 0010 returns 2222.
  - A req held high during WAIT is ignored (single response only).
